// File: rtl/axi_read_arbiter_if.sv
// AR/R bundle between the fetch/load requesters, the arbiter and the AXI read port.
// The slave modport is the arbiter's view; the master modport is the requester/fabric side.
interface axi_read_arbiter_if;
  logic        inst_arvalid;
  logic [31:0] inst_araddr;
  logic [3:0]  inst_arlen;
  logic        inst_arready;
  logic        data_arvalid;
  logic [31:0] data_araddr;
  logic [3:0]  data_arlen;
  logic        data_arready;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  arbitrate_arid;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        inst_rvalid;
  logic        data_rvalid;
  logic        inst_rready;
  logic        data_rready;

  modport slave (
    input  inst_arvalid, inst_araddr, inst_arlen,
    input  data_arvalid, data_araddr, data_arlen,
    output inst_arready, data_arready,
    output arid, araddr, arlen, arsize, arburst, arvalid, arbitrate_arid,
    input  arready,
    input  rid, rlast, rvalid, inst_rready, data_rready,
    output rready, inst_rvalid, data_rvalid
  );

  modport master (
    output inst_arvalid, inst_araddr, inst_arlen,
    output data_arvalid, data_araddr, data_arlen,
    input  inst_arready, data_arready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, arbitrate_arid,
    output arready,
    output rid, rdata, rlast, rvalid, inst_rready, data_rready,
    input  rready, inst_rvalid, data_rvalid
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read port between instruction fetch and data load: registered AR
// arbitration (round-robin on ties), R routing by rid, and per-requester outstanding limits.
module axi_read_arbiter #(
  parameter logic [3:0] INST_ID         = 4'h0,
  parameter logic [3:0] DATA_ID         = 4'h1,
  parameter int         MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  axi_read_arbiter_if.slave     bus
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic       GNT_INST = 1'b0;
  localparam logic       GNT_DATA = 1'b1;
  localparam logic [1:0] MAX_CNT  = 2'(MAX_OUTSTANDING);

  state_t      state_q;
  logic        arvalid_q;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [3:0]  arlen_q;
  logic        grant_q;
  logic        last_grant_q;
  logic [1:0]  cnt_inst_q, cnt_inst_d;
  logic [1:0]  cnt_data_q, cnt_data_d;

  logic inst_elig, data_elig, pick_data;
  logic ar_hs, inst_hs, data_hs;
  logic rready_c, inst_done, data_done;

  // Saturating at both ends so a stray beat or handshake can never wrap the count.
  function automatic logic [1:0] next_cnt(input logic [1:0] c, input logic inc, input logic dec);
    logic [1:0] n;
    n = c;
    if (inc && !dec && c != 2'd3)
      n = c + 2'd1;
    else if (dec && !inc && c != 2'd0)
      n = c - 2'd1;
    return n;
  endfunction

  always_comb begin
    inst_elig = bus.inst_arvalid && (cnt_inst_q < MAX_CNT);
    data_elig = bus.data_arvalid && (cnt_data_q < MAX_CNT);
    pick_data = data_elig && (!inst_elig || last_grant_q == GNT_INST);

    ar_hs   = arvalid_q && bus.arready;
    inst_hs = ar_hs && (grant_q == GNT_INST);
    data_hs = ar_hs && (grant_q == GNT_DATA);

    if (bus.rid == INST_ID)
      rready_c = bus.inst_rready;
    else if (bus.rid == DATA_ID)
      rready_c = bus.data_rready;
    else
      rready_c = 1'b1;

    inst_done = bus.rvalid && rready_c && bus.rlast && (bus.rid == INST_ID);
    data_done = bus.rvalid && rready_c && bus.rlast && (bus.rid == DATA_ID);

    cnt_inst_d = next_cnt(cnt_inst_q, inst_hs, inst_done);
    cnt_data_d = next_cnt(cnt_data_q, data_hs, data_done);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      arvalid_q    <= 1'b0;
      arid_q       <= 4'h0;
      araddr_q     <= 32'h0;
      arlen_q      <= 4'h0;
      grant_q      <= GNT_INST;
      last_grant_q <= GNT_INST;
    end else begin
      case (state_q)
        IDLE: begin
          if (inst_elig || data_elig) begin
            arvalid_q <= 1'b1;
            grant_q   <= pick_data;
            state_q   <= ISSUE;
            if (pick_data) begin
              arid_q   <= DATA_ID;
              araddr_q <= bus.data_araddr;
              arlen_q  <= bus.data_arlen;
            end else begin
              arid_q   <= INST_ID;
              araddr_q <= bus.inst_araddr;
              arlen_q  <= bus.inst_arlen;
            end
          end
        end
        ISSUE: begin
          // Payload is held even if the requester withdraws; it still owns the response.
          if (bus.arready) begin
            arvalid_q    <= 1'b0;
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_inst_q <= 2'd0;
      cnt_data_q <= 2'd0;
    end else begin
      cnt_inst_q <= cnt_inst_d;
      cnt_data_q <= cnt_data_d;
    end
  end

  assign bus.arvalid        = arvalid_q;
  assign bus.arid           = arid_q;
  assign bus.araddr         = araddr_q;
  assign bus.arlen          = arlen_q;
  assign bus.arsize         = 3'b010;
  assign bus.arburst        = 2'b01;
  assign bus.arbitrate_arid = arid_q;
  assign bus.inst_arready   = inst_hs;
  assign bus.data_arready   = data_hs;

  assign bus.rready      = rready_c;
  assign bus.inst_rvalid = bus.rvalid && (bus.rid == INST_ID);
  assign bus.data_rvalid = bus.rvalid && (bus.rid == DATA_ID);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter; expected AR transfers are queued at issue time
// and a negedge monitor checks every AR handshake against the queue.
module tb_axi_read_arbiter;

  logic clk;
  logic resetn;
  axi_read_arbiter_if bus();

  axi_read_arbiter #(.INST_ID(4'h0), .DATA_ID(4'h1), .MAX_OUTSTANDING(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
  } ar_t;

  ar_t sb[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] id, input logic [31:0] a, input logic [3:0] l);
    ar_t e;
    e.id = id; e.addr = a; e.len = l;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic handshake;
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    chk("arvalid_drop", 32'(bus.arvalid), 32'd0);
  endtask

  task automatic expect_ar(input string nm, input logic [3:0] id, input logic [31:0] a,
                           input logic [3:0] l);
    chk({nm, "_arvalid"}, 32'(bus.arvalid), 32'd1);
    chk({nm, "_arid"}, 32'(bus.arid), 32'(id));
    chk({nm, "_araddr"}, bus.araddr, a);
    chk({nm, "_arlen"}, 32'(bus.arlen), 32'(l));
    chk({nm, "_arbitrate_arid"}, 32'(bus.arbitrate_arid), 32'(id));
  endtask

  task automatic clear_inputs;
    bus.inst_arvalid = 1'b0; bus.inst_araddr = 32'h0; bus.inst_arlen = 4'h0;
    bus.data_arvalid = 1'b0; bus.data_araddr = 32'h0; bus.data_arlen = 4'h0;
    bus.arready = 1'b0;
    bus.rid = 4'h0; bus.rdata = 32'h0; bus.rlast = 1'b0; bus.rvalid = 1'b0;
    bus.inst_rready = 1'b0; bus.data_rready = 1'b0;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    clear_inputs();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // AR monitor: every handshake must match the head of the scoreboard.
  initial begin
    ar_t e;
    forever begin
      @(negedge clk);
      if (resetn && bus.arvalid && bus.arready) begin
        if (sb.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL ar_unexpected: got arid %h araddr %h, expected no transfer", bus.arid, bus.araddr);
        end else begin
          e = sb.pop_front();
          chk("mon_arid", 32'(bus.arid), 32'(e.id));
          chk("mon_araddr", bus.araddr, e.addr);
          chk("mon_arlen", 32'(bus.arlen), 32'(e.len));
          chk("mon_arsize", 32'(bus.arsize), 32'd2);
          chk("mon_arburst", 32'(bus.arburst), 32'd1);
          chk("mon_inst_arready", 32'(bus.inst_arready), 32'(e.id == 4'h0));
          chk("mon_data_arready", 32'(bus.data_arready), 32'(e.id == 4'h1));
        end
      end else begin
        chk("mon_arready_idle", {30'd0, bus.inst_arready, bus.data_arready}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
    chk("rst_arid", 32'(bus.arid), 32'd0);
    chk("rst_araddr", bus.araddr, 32'd0);
    chk("rst_arlen", 32'(bus.arlen), 32'd0);

    // 1: inst only, arready three cycles after request
    bus.inst_arvalid = 1'b1; bus.inst_araddr = 32'hbfc0_0040; bus.inst_arlen = 4'hF;
    push(4'h0, 32'hbfc0_0040, 4'hF);
    #1 chk("t1_pre_arvalid", 32'(bus.arvalid), 32'd0);
    tick();
    expect_ar("t1", 4'h0, 32'hbfc0_0040, 4'hF);
    bus.inst_arvalid = 1'b0;
    tick(); chk("t1_hold1", 32'(bus.arvalid), 32'd1);
    tick(); chk("t1_hold2", 32'(bus.arvalid), 32'd1);
    handshake();

    // 2: tie in the first cycle after reset goes to DATA
    do_reset();
    bus.inst_arvalid = 1'b1; bus.inst_araddr = 32'h0000_1000; bus.inst_arlen = 4'h3;
    bus.data_arvalid = 1'b1; bus.data_araddr = 32'h8000_0004; bus.data_arlen = 4'h0;
    push(4'h1, 32'h8000_0004, 4'h0);
    push(4'h0, 32'h0000_1000, 4'h3);
    tick();
    expect_ar("t2_data", 4'h1, 32'h8000_0004, 4'h0);
    bus.data_arvalid = 1'b0;
    handshake();
    tick();
    expect_ar("t2_inst", 4'h0, 32'h0000_1000, 4'h3);
    bus.inst_arvalid = 1'b0;
    handshake();

    // 3: data outstanding limit, released by a last beat
    do_reset();
    bus.data_arvalid = 1'b1; bus.data_araddr = 32'h2000_0000; bus.data_arlen = 4'h1;
    push(4'h1, 32'h2000_0000, 4'h1);
    tick();
    expect_ar("t3_a", 4'h1, 32'h2000_0000, 4'h1);
    bus.data_araddr = 32'h2000_0010;
    push(4'h1, 32'h2000_0010, 4'h1);
    handshake();
    tick();
    expect_ar("t3_b", 4'h1, 32'h2000_0010, 4'h1);
    bus.data_araddr = 32'h2000_0020;
    push(4'h1, 32'h2000_0020, 4'h1);
    handshake();
    for (int i = 0; i < 3; i++) begin
      chk("t3_blocked", 32'(bus.arvalid), 32'd0);
      tick();
    end
    bus.rvalid = 1'b1; bus.rid = 4'h1; bus.rlast = 1'b1; bus.data_rready = 1'b1;
    bus.rdata = 32'hdead_beef;
    @(negedge clk);
    chk("t3_rready", 32'(bus.rready), 32'd1);
    chk("t3_data_rvalid", 32'(bus.data_rvalid), 32'd1);
    chk("t3_inst_rvalid", 32'(bus.inst_rvalid), 32'd0);
    tick();
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.data_rready = 1'b0;
    chk("t3_not_yet", 32'(bus.arvalid), 32'd0);
    tick();
    expect_ar("t3_c", 4'h1, 32'h2000_0020, 4'h1);
    bus.data_arvalid = 1'b0;
    handshake();

    // 4: inst withdraws while its AR is waiting for arready
    do_reset();
    bus.inst_arvalid = 1'b1; bus.inst_araddr = 32'h1000_0040; bus.inst_arlen = 4'h7;
    push(4'h0, 32'h1000_0040, 4'h7);
    tick();
    bus.inst_arvalid = 1'b0; bus.inst_araddr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      expect_ar("t4_hold", 4'h0, 32'h1000_0040, 4'h7);
      tick();
    end
    handshake();
    tick();
    chk("t4_no_reissue", 32'(bus.arvalid), 32'd0);

    // 5: R routing by rid
    bus.rvalid = 1'b1; bus.rid = 4'h0; bus.inst_rready = 1'b0; bus.data_rready = 1'b1;
    #1;
    chk("t5_rid0_rready", 32'(bus.rready), 32'd0);
    chk("t5_rid0_inst_rvalid", 32'(bus.inst_rvalid), 32'd1);
    chk("t5_rid0_data_rvalid", 32'(bus.data_rvalid), 32'd0);
    bus.inst_rready = 1'b1; bus.data_rready = 1'b0;
    #1 chk("t5_rid0_rready_hi", 32'(bus.rready), 32'd1);
    bus.rid = 4'h5; bus.inst_rready = 1'b0;
    #1;
    chk("t5_rid5_rready", 32'(bus.rready), 32'd1);
    chk("t5_rid5_inst_rvalid", 32'(bus.inst_rvalid), 32'd0);
    chk("t5_rid5_data_rvalid", 32'(bus.data_rvalid), 32'd0);
    bus.rvalid = 1'b0; bus.rid = 4'h0;

    // 6: async reset mid-ISSUE with data saturated and last_grant=DATA
    do_reset();
    bus.data_arvalid = 1'b1; bus.data_araddr = 32'h3000_0000; bus.data_arlen = 4'h0;
    push(4'h1, 32'h3000_0000, 4'h0);
    push(4'h1, 32'h3000_0000, 4'h0);
    tick(); handshake();
    tick(); handshake();
    bus.data_arvalid = 1'b0;
    bus.inst_arvalid = 1'b1; bus.inst_araddr = 32'h4000_0000; bus.inst_arlen = 4'h2;
    tick();
    expect_ar("t6_pre", 4'h0, 32'h4000_0000, 4'h2);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_arvalid", 32'(bus.arvalid), 32'd0);
    chk("t6_rst_arid", 32'(bus.arid), 32'd0);
    chk("t6_rst_araddr", bus.araddr, 32'd0);
    chk("t6_rst_arbitrate_arid", 32'(bus.arbitrate_arid), 32'd0);
    clear_inputs();
    sb.delete();
    tick();
    resetn = 1'b1;
    bus.inst_arvalid = 1'b1; bus.inst_araddr = 32'h5000_0000; bus.inst_arlen = 4'h1;
    bus.data_arvalid = 1'b1; bus.data_araddr = 32'h6000_0008; bus.data_arlen = 4'h2;
    push(4'h1, 32'h6000_0008, 4'h2);
    push(4'h0, 32'h5000_0000, 4'h1);
    tick();
    expect_ar("t6_data", 4'h1, 32'h6000_0008, 4'h2);
    bus.data_arvalid = 1'b0;
    handshake();
    tick();
    expect_ar("t6_inst", 4'h0, 32'h5000_0000, 4'h1);
    bus.inst_arvalid = 1'b0;
    handshake();
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
